// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit with architectural HI/LO registers.
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_start          start request, accepted only when idle
//   i_op             0 = multiply, 1 = divide
//   i_sign           1 = signed (mult/div), 0 = unsigned (multu/divu)
//   i_a, i_b         rs / rt operands
//   i_hi_we/i_lo_we  mthi / mtlo write enables (idle only)
//   i_wdata          mthi / mtlo data
//   o_busy           operation in progress (pipeline stall)
//   o_done           one-cycle pulse after HI/LO were written by an operation
//   o_hi, o_lo       HI / LO registers
//
// An operation spends WIDTH cycles in CALC working on unsigned magnitudes, then one cycle in
// FIX applying signs and writing HI/LO.

module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_op,
    input  logic             i_sign,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    // Multiply: a_mag is the fixed multiplicand, b_mag shifts right to expose multiplier bits.
    // Divide: a_mag shifts left feeding dividend bits, b_mag is the fixed divisor.
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    // Multiply: {partial product high, low}. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               div_by_zero;

    assign a_neg = i_a[WIDTH-1] & i_sign;
    assign b_neg = i_b[WIDTH-1] & i_sign;

    // Datapath for one iteration plus the sign fix-up.
    always_comb begin
        mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (b_mag_q[0] ? {1'b0, a_mag_q} : {(WIDTH + 1){1'b0}});
        div_shift   = {acc_q[2*WIDTH-1:WIDTH], a_mag_q[WIDTH-1]};
        div_diff    = div_shift - {1'b0, b_mag_q};
        div_ge      = (div_shift >= {1'b0, b_mag_q});
        prod_fix    = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix     = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix     = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        // b_mag is not shifted during divide, so it still holds the divisor at FIX.
        div_by_zero = (b_mag_q == '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_hi_we) begin
                    hi_d = i_wdata;
                end
                if (i_lo_we) begin
                    lo_d = i_wdata;
                end
                if (i_start) begin
                    state_d = StCalc;
                    op_d    = i_op;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    a_mag_d = a_neg ? -i_a : i_a;
                    b_mag_d = b_neg ? -i_b : i_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            StCalc: begin
                if (!op_q) begin
                    // Shift-add: carry out of the add becomes the new top bit.
                    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
                    b_mag_d = b_mag_q >> 1;
                end else begin
                    // Restoring divide: remainder always fits WIDTH bits since it stays < divisor.
                    acc_d   = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                               acc_q[WIDTH-2:0], div_ge};
                    a_mag_d = a_mag_q << 1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end

            StFix: begin
                if (!op_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div_by_zero) begin
                    // Remainder equals |a|; re-signing it restores the original dividend.
                    lo_d = '1;
                    hi_d = rem_fix;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
